// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared FSM state type and width helper for the 1xN router
package demux_pkg;

  typedef enum logic {
    PASS = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Ceiling log2 for elaboration-time select width.
  function automatic int demux_clog2(input int value);
    int width;
    int rem;
    width = 0;
    rem   = value - 1;
    for (int i = 0; i < 32; i++) begin
      if (rem > 0) begin
        width = width + 1;
        rem   = rem >> 1;
      end
    end
    return width;
  endfunction

endpackage

// File: rtl/demux_target_dec.sv
// rtl/demux_target_dec.sv - maps (select, bcast) onto a channel target mask
module demux_target_dec
  import demux_pkg::*;
#(
  parameter int N_OUT = 4,
  parameter int SEL_W = demux_clog2(N_OUT)
) (
  input  logic [SEL_W-1:0] select_i,
  input  logic             bcast_i,
  output logic [N_OUT-1:0] target_o,
  output logic             illegal_o
);

  // An out-of-range select matches no channel, so an empty mask marks it illegal.
  always_comb begin
    target_o = '0;
    for (int i = 0; i < N_OUT; i++) begin
      target_o[i] = bcast_i | (select_i == SEL_W'(i));
    end
    illegal_o = ~|target_o;
  end

endmodule

// File: rtl/demux_1xn_route.sv
// rtl/demux_1xn_route.sv - 1-to-N word router with all-or-nothing backpressure hold
module demux_1xn_route
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4,
  parameter int SEL_W  = demux_clog2(N_OUT)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       in,
  input  logic                    valid_in,
  input  logic [SEL_W-1:0]        select,
  input  logic                    bcast,
  input  logic [N_OUT-1:0]        almost_full,
  output logic                    ready_in,
  output logic [N_OUT*DATA_W-1:0] out,
  output logic [N_OUT-1:0]        push,
  output logic [7:0]              drop_cnt,
  output logic                    err
);

  state_e                    state_q, state_d;
  logic [DATA_W-1:0]         hold_data_q, hold_data_d;
  logic [N_OUT-1:0]          hold_mask_q, hold_mask_d;
  logic [N_OUT*DATA_W-1:0]   out_q, out_d;
  logic [N_OUT-1:0]          push_q, push_d;
  logic [7:0]                drop_cnt_q, drop_cnt_d;
  logic                      err_q, err_d;

  logic [N_OUT-1:0]          target;
  logic                      illegal;
  logic                      xfer;
  logic [N_OUT-1:0]          emit_mask;
  logic [DATA_W-1:0]         emit_data;

  demux_target_dec #(
    .N_OUT (N_OUT),
    .SEL_W (SEL_W)
  ) u_target_dec (
    .select_i  (select),
    .bcast_i   (bcast),
    .target_o  (target),
    .illegal_o (illegal)
  );

  // Decoded from state and reset only; valid_in never reaches ready_in.
  assign ready_in = (state_q == PASS) & ~reset;
  assign xfer     = valid_in & ready_in;

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_mask_d = hold_mask_q;
    drop_cnt_d  = drop_cnt_q;
    err_d       = 1'b0;
    emit_mask   = '0;
    emit_data   = in;

    case (state_q)
      PASS: begin
        if (xfer) begin
          if (illegal) begin
            err_d = 1'b1;
            if (drop_cnt_q != 8'hFF) begin
              drop_cnt_d = drop_cnt_q + 8'd1;
            end
          end else if ((target & almost_full) != '0) begin
            // Any blocked target parks the whole word so broadcast stays atomic.
            state_d     = HOLD;
            hold_data_d = in;
            hold_mask_d = target;
          end else begin
            emit_mask = target;
            emit_data = in;
          end
        end
      end
      HOLD: begin
        if ((hold_mask_q & almost_full) == '0) begin
          emit_mask   = hold_mask_q;
          emit_data   = hold_data_q;
          state_d     = PASS;
          hold_mask_d = '0;
          hold_data_d = '0;
        end
      end
      default: begin
        state_d = PASS;
      end
    endcase

    push_d = emit_mask;
    out_d  = out_q;
    for (int i = 0; i < N_OUT; i++) begin
      if (emit_mask[i]) begin
        out_d[i*DATA_W +: DATA_W] = emit_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= PASS;
      hold_data_q <= '0;
      hold_mask_q <= '0;
      out_q       <= '0;
      push_q      <= '0;
      drop_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_mask_q <= hold_mask_d;
      out_q       <= out_d;
      push_q      <= push_d;
      drop_cnt_q  <= drop_cnt_d;
      err_q       <= err_d;
    end
  end

  assign out      = out_q;
  assign push     = push_q;
  assign drop_cnt = drop_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_demux_1xn_route.sv
// tb/tb_demux_1xn_route.sv - self-checking bench for demux_1xn_route (N_OUT=4 and N_OUT=3)
module tb_demux_1xn_route;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  in4;
  logic        valid4;
  logic [1:0]  sel4;
  logic        bcast4;
  logic [3:0]  af4;
  logic        ready4;
  logic [31:0] out4;
  logic [3:0]  push4;
  logic [7:0]  drop4;
  logic        err4;

  logic [7:0]  in3;
  logic        valid3;
  logic [1:0]  sel3;
  logic        bcast3;
  logic [2:0]  af3;
  logic        ready3;
  logic [23:0] out3;
  logic [2:0]  push3;
  logic [7:0]  drop3;
  logic        err3;

  int n_checks = 0;
  int n_fail   = 0;

  demux_1xn_route #(.DATA_W(8), .N_OUT(4)) dut4 (
    .clk(clk), .reset(reset), .in(in4), .valid_in(valid4), .select(sel4), .bcast(bcast4),
    .almost_full(af4), .ready_in(ready4), .out(out4), .push(push4), .drop_cnt(drop4), .err(err4)
  );

  demux_1xn_route #(.DATA_W(8), .N_OUT(3)) dut3 (
    .clk(clk), .reset(reset), .in(in3), .valid_in(valid3), .select(sel3), .bcast(bcast3),
    .almost_full(af3), .ready_in(ready3), .out(out3), .push(push3), .drop_cnt(drop3), .err(err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_checks++; if (push4 !== 4'h0) begin n_fail++; $display("FAIL reset_push: got %b want 0000", push4); end
    n_checks++; if (out4 !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out4); end
    n_checks++; if (drop4 !== 8'h0 || err4 !== 1'b0) begin n_fail++; $display("FAIL reset_drop_err: got %h/%b want 00/0", drop4, err4); end
    n_checks++; if (ready4 !== 1'b0) begin n_fail++; $display("FAIL reset_ready_high: got %b want 0", ready4); end
    n_checks++; if (push3 !== 3'h0 || out3 !== 24'h0) begin n_fail++; $display("FAIL reset_dut3: got %b/%h want 0/0", push3, out3); end
    reset = 1'b0;
    #1;
    n_checks++; if (ready4 !== 1'b1) begin n_fail++; $display("FAIL reset_ready_release: got %b want 1", ready4); end
  endtask

  task automatic test_single();
    valid4 = 1'b1; sel4 = 2'd2; in4 = 8'hA5; af4 = 4'h0; bcast4 = 1'b0;
    tick();
    valid4 = 1'b0;
    n_checks++; if (push4 !== 4'b0100) begin n_fail++; $display("FAIL single_push: got %b want 0100", push4); end
    n_checks++; if (out4[23:16] !== 8'hA5) begin n_fail++; $display("FAIL single_lane2: got %h want a5", out4[23:16]); end
    n_checks++; if (ready4 !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", ready4); end
    tick();
    n_checks++; if (push4 !== 4'b0000) begin n_fail++; $display("FAIL single_push_once: got %b want 0000", push4); end
  endtask

  task automatic test_hold();
    bit bad = 0;
    af4 = 4'b0010; valid4 = 1'b1; sel4 = 2'd1; in4 = 8'h3C;
    tick();
    // junk offered while holding must be ignored
    sel4 = 2'd0; in4 = 8'hFF;
    n_checks++; if (ready4 !== 1'b0 || push4 !== 4'h0) begin n_fail++; $display("FAIL hold_enter: ready %b push %b want 0 0000", ready4, push4); end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ready4 !== 1'b0 || push4 !== 4'h0) bad = 1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL hold_wait: ready %b push %b want 0 0000", ready4, push4); end
    af4 = 4'h0;
    tick();
    valid4 = 1'b0;
    n_checks++; if (push4 !== 4'b0010 || out4[15:8] !== 8'h3C) begin n_fail++; $display("FAIL hold_release: push %b lane1 %h want 0010 3c", push4, out4[15:8]); end
    n_checks++; if (ready4 !== 1'b1) begin n_fail++; $display("FAIL hold_back_pass: got %b want 1", ready4); end
    tick();
    n_checks++; if (push4 !== 4'h0 || out4[7:0] !== 8'h00) begin n_fail++; $display("FAIL hold_ignored_input: push %b lane0 %h want 0000 00", push4, out4[7:0]); end
  endtask

  task automatic test_bcast();
    bit bad = 0;
    bcast4 = 1'b1; sel4 = 2'd0; in4 = 8'h77; af4 = 4'b1000; valid4 = 1'b1;
    tick();
    valid4 = 1'b0; bcast4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (push4 !== 4'h0 || ready4 !== 1'b0) bad = 1;
      tick();
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL bcast_partial: push %b ready %b want 0000 0", push4, ready4); end
    af4 = 4'h0;
    tick();
    n_checks++; if (push4 !== 4'b1111 || out4 !== {4{8'h77}}) begin n_fail++; $display("FAIL bcast_release: push %b out %h want 1111 77777777", push4, out4); end
    tick();
    n_checks++; if (push4 !== 4'h0) begin n_fail++; $display("FAIL bcast_single: got %b want 0000", push4); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d [4];
    bit rdy_bad = 0;
    af4 = 4'h0; bcast4 = 1'b0; valid4 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      d[k] = 8'($urandom);
      sel4 = 2'(k); in4 = d[k];
      #1;
      if (ready4 !== 1'b1) rdy_bad = 1;
      tick();
      n_checks++;
      if (push4 !== 4'(1 << k) || out4[8*k +: 8] !== d[k]) begin
        n_fail++; $display("FAIL b2b_word%0d: push %b lane %h want %b %h", k, push4, out4[8*k +: 8], 4'(1 << k), d[k]);
      end
    end
    valid4 = 1'b0;
    n_checks++; if (rdy_bad) begin n_fail++; $display("FAIL b2b_ready: ready dropped, want continuous 1"); end
    tick();
    n_checks++; if (push4 !== 4'h0) begin n_fail++; $display("FAIL b2b_idle: got %b want 0000", push4); end
  endtask

  task automatic test_reset_in_hold();
    bit bad = 0;
    af4 = 4'b0001; valid4 = 1'b1; sel4 = 2'd0; in4 = 8'h5A; bcast4 = 1'b0;
    tick();
    valid4 = 1'b0;
    n_checks++; if (ready4 !== 1'b0) begin n_fail++; $display("FAIL rsthold_in_hold: got %b want 0", ready4); end
    reset = 1'b1; af4 = 4'h0;
    tick();
    n_checks++; if (push4 !== 4'h0 || out4 !== 32'h0 || err4 !== 1'b0 || drop4 !== 8'h0 || ready4 !== 1'b0) begin
      n_fail++; $display("FAIL rsthold_zero: push %b out %h err %b drop %h ready %b want all 0", push4, out4, err4, drop4, ready4);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (push4 !== 4'h0 || out4 !== 32'h0) bad = 1;
    end
    n_checks++; if (bad) begin n_fail++; $display("FAIL rsthold_no_push: push %b out %h want 0000 0", push4, out4); end
  endtask

  task automatic test_drop();
    int errs = 0;
    int pushes = 0;
    bit rdy_bad = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    valid3 = 1'b1; sel3 = 2'd3; bcast3 = 1'b0; af3 = 3'h0;
    for (int i = 0; i < 300; i++) begin
      in3 = 8'($urandom);
      #1;
      if (ready3 !== 1'b1) rdy_bad = 1;
      tick();
      if (err3 === 1'b1) errs++;
      if (push3 !== 3'h0) pushes++;
      if (i == 0) begin
        n_checks++; if (drop3 !== 8'd1) begin n_fail++; $display("FAIL drop_first: got %0d want 1", drop3); end
      end
      if (i == 254 || i == 299) begin
        n_checks++; if (drop3 !== 8'd255) begin n_fail++; $display("FAIL drop_sat_%0d: got %0d want 255", i + 1, drop3); end
      end
    end
    valid3 = 1'b0;
    tick();
    n_checks++; if (errs != 300) begin n_fail++; $display("FAIL drop_err_pulses: got %0d want 300", errs); end
    n_checks++; if (pushes != 0) begin n_fail++; $display("FAIL drop_pushes: got %0d want 0", pushes); end
    n_checks++; if (err3 !== 1'b0 || drop3 !== 8'd255 || rdy_bad) begin n_fail++; $display("FAIL drop_end: err %b drop %0d rdybad %0d want 0 255 0", err3, drop3, rdy_bad); end
    valid3 = 1'b1; bcast3 = 1'b1; sel3 = 2'd3; in3 = 8'h42;
    tick();
    valid3 = 1'b0; bcast3 = 1'b0;
    n_checks++; if (push3 !== 3'b111 || out3 !== {3{8'h42}} || err3 !== 1'b0) begin
      n_fail++; $display("FAIL drop_bcast_ignores_sel: push %b out %h err %b want 111 424242 0", push3, out3, err3);
    end
  endtask

  // Reference model: transaction-level rules for routing, atomic hold and reset.
  task automatic test_random();
    logic [7:0] m_lane [4];
    bit         busy = 0;
    logic [3:0] pmask = '0;
    logic [7:0] pdata = '0;
    int         drops = 0;
    logic [3:0] exp_push;
    logic [3:0] tmask;
    logic [31:0] exp_out;
    bit         r_rst, v, bc;
    logic [1:0] s;
    logic [7:0] d;
    logic [3:0] af;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_lane[i] = 8'h0;
    for (int c = 0; c < 500; c++) begin
      r_rst = ($urandom_range(0, 79) == 0);
      v     = ($urandom_range(0, 3) != 0);
      bc    = ($urandom_range(0, 7) == 0);
      s     = 2'($urandom_range(0, 3));
      d     = 8'($urandom);
      af    = 4'($urandom) & 4'($urandom);
      reset = r_rst; valid4 = v; bcast4 = bc; sel4 = s; in4 = d; af4 = af;
      #1;
      n_checks++; if (ready4 !== (!r_rst && !busy)) begin n_fail++; $display("FAIL rand_ready c%0d: got %b want %b", c, ready4, (!r_rst && !busy)); end
      tick();
      exp_push = '0;
      if (r_rst) begin
        busy = 0; drops = 0;
        for (int i = 0; i < 4; i++) m_lane[i] = 8'h0;
      end else if (busy) begin
        if ((pmask & af) == 0) begin
          exp_push = pmask;
          for (int i = 0; i < 4; i++) if (pmask[i]) m_lane[i] = pdata;
          busy = 0;
        end
      end else if (v) begin
        tmask = bc ? 4'hF : 4'(1 << s);
        if ((tmask & af) != 0) begin
          busy = 1; pmask = tmask; pdata = d;
        end else begin
          exp_push = tmask;
          for (int i = 0; i < 4; i++) if (tmask[i]) m_lane[i] = d;
        end
      end
      exp_out = {m_lane[3], m_lane[2], m_lane[1], m_lane[0]};
      n_checks++; if (push4 !== exp_push) begin n_fail++; $display("FAIL rand_push c%0d: got %b want %b", c, push4, exp_push); end
      n_checks++; if (out4 !== exp_out) begin n_fail++; $display("FAIL rand_out c%0d: got %h want %h", c, out4, exp_out); end
      n_checks++; if (err4 !== 1'b0 || drop4 !== 8'(drops)) begin n_fail++; $display("FAIL rand_drop c%0d: err %b drop %0d want 0 %0d", c, err4, drop4, drops); end
    end
    reset = 1'b0; valid4 = 1'b0; af4 = 4'h0;
  endtask

  initial begin
    reset = 1'b1;
    in4 = '0; valid4 = 1'b0; sel4 = '0; bcast4 = 1'b0; af4 = '0;
    in3 = '0; valid3 = 1'b0; sel3 = '0; bcast3 = 1'b0; af3 = '0;
    test_reset();
    test_single();
    test_hold();
    test_bcast();
    test_back_to_back();
    test_reset_in_hold();
    test_drop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1xn_route.md
DEMUX_1XN_ROUTE -- requirements
Module: demux_1xn_route

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, as the data word width.
REQ-002 The block SHALL take parameter N_OUT, default 4, as the output channel count; legal range 2..16.
REQ-003 The block SHALL take parameter SEL_W, default clog2(N_OUT), as the select width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic on posedge clk.
REQ-005 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have port in, input, DATA_W, the input word.
REQ-007 The block SHALL have port valid_in, input, 1; a word transfers when valid_in=1 and ready_in=1 in the same cycle.
REQ-008 The block SHALL have port select, input, SEL_W, the destination channel index.
REQ-009 The block SHALL have port bcast, input, 1, which sends the word to all channels when set (select ignored).
REQ-010 The block SHALL have port almost_full, input, N_OUT, with per-channel downstream FIFO backpressure.
REQ-011 The block SHALL have port ready_in, output, 1, indicating the block accepts a word this cycle.
REQ-012 The block SHALL have port out, output, N_OUT*DATA_W, holding per-channel data lanes; lane i is bits [i*DATA_W +: DATA_W].
REQ-013 The block SHALL have port push, output, N_OUT, carrying per-channel one-cycle write strobes.
REQ-014 The block SHALL have port drop_cnt, output, 8, a saturating count of words dropped for illegal select.
REQ-015 The block SHALL have port err, output, 1, a one-cycle pulse on each drop.

Function
REQ-016 The block SHALL derive target mask T: bcast=1 gives all ones; otherwise one-hot(select); select>=N_OUT gives T=0 (illegal).
REQ-017 The block SHALL have a two-state FSM: PASS (ready_in=1) and HOLD (ready_in=0).
REQ-018 In PASS, on transfer with T!=0 and (T & almost_full)==0, the block SHALL, next cycle, drive out lane(s) in T with in and push[T]=1; latency exactly 1 cycle; FSM stays PASS.
REQ-019 In PASS, on transfer with T!=0 and (T & almost_full)!=0, the block SHALL capture in and T into a hold register, assert no push, and go to HOLD.
REQ-020 In HOLD, each cycle in which (T_hold & almost_full)==0, the block SHALL emit the held word to all lanes in T_hold with push one cycle later and return to PASS; otherwise it stays in HOLD.
REQ-021 Broadcast SHALL be all-or-nothing: no partial push while any target channel is almost_full.
REQ-022 In HOLD, valid_in, in, select and bcast SHALL be ignored; the sender keeps the word until ready_in=1.
REQ-023 On transfer with T=0, the block SHALL push nothing, pulse err next cycle, and increment drop_cnt, saturating at 255 with no wrap; FSM stays PASS.
REQ-024 Lanes not pushed in a cycle SHALL hold their previous value; push SHALL default to 0 every cycle not set by REQ-018/020.
REQ-025 ready_in SHALL be a registered/state-decoded output with no combinational path from valid_in.
REQ-026 The block SHALL sustain throughput of one word per cycle in PASS with no backpressure.

Reset
REQ-027 While reset=1 at posedge clk, the block SHALL set FSM to PASS, out=0, push=0, drop_cnt=0, err=0, and hold register=0.
REQ-028 ready_in SHALL be 0 while reset is high and 1 from the first cycle after deassertion.
REQ-029 Reset asserted in HOLD SHALL discard the held word; no push SHALL follow.

Structure
REQ-030 Package demux_pkg SHALL hold the FSM state type (PASS, HOLD) and the clog2 constant function.
REQ-031 Sub-module demux_target_dec SHALL map (select, bcast) to T and the illegal flag, parameterised by N_OUT and SEL_W.

Verification
REQ-032 Reset then valid_in=1, select=2, in=8'hA5, almost_full=0 -> next cycle push=4'b0100, lane2=8'hA5, ready_in=1.
REQ-033 almost_full=4'b0010, send select=1, in=8'h3C -> HOLD, ready_in=0, no push; drop almost_full after 3 cycles -> next cycle push=4'b0010, lane1=8'h3C, back to PASS.
REQ-034 bcast=1, in=8'h77, almost_full=4'b1000 -> HOLD, no pushes; clear almost_full -> single cycle push=4'b1111, all lanes 8'h77.
REQ-035 With N_OUT=3, send 300 words with select=3 -> zero pushes, 300 err pulses, drop_cnt=255.
REQ-036 Back-to-back words selecting 0,1,2,3 with no backpressure -> pushes one per cycle in order, ready_in continuously 1.
REQ-037 Assert reset while in HOLD holding 8'h5A -> all outputs zero, no push of 8'h5A after release.
